// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int          INSTR_W      = 16;
    localparam logic [3:0]  OPC_HLT      = 4'hF;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;
    localparam logic [15:0] PC_STEP      = 16'h0002;
    localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    // True when the fetched word carries the halt opcode.
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage and the memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               req;
    logic [15:0]        addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/fetch_unit_cla_16b.sv
// 16-bit two-level carry-lookahead adder/subtractor (4-bit groups).
// The carry out of the top bit is not produced; PC arithmetic wraps silently.
module CLA_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    logic [15:0] b_eff;
    logic [15:0] p;
    logic [14:0] g;
    logic [15:0] c;
    logic [2:0]  grp_g;
    logic [2:0]  grp_p;
    logic [3:0]  grp_c;

    // Lookahead carries c1..c3 from three generate/propagate pairs.
    function automatic logic [2:0] carries3(input logic [2:0] gi,
                                            input logic [2:0] pi,
                                            input logic       c0);
        logic [2:0] co;
        co[0] = gi[0] | (pi[0] & c0);
        co[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c0);
        co[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & c0);
        return co;
    endfunction

    assign b_eff = b ^ {16{sub}};
    assign p     = a ^ b_eff;
    assign g     = a[14:0] & b_eff[14:0];

    // Group generate/propagate for the lower three groups; the top group's carry out is not needed.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 3; k++) begin
            grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // Second-level lookahead for group carries, then bit carries inside each group.
    always_comb begin
        grp_c[0]   = sub;
        grp_c[3:1] = carries3(grp_g, grp_p, sub);
        c          = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]        = grp_c[k];
            c[4*k+1 +: 3] = carries3(g[4*k +: 3], p[4*k +: 3], grp_c[k]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID latch, halt detection.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_RUN    | fetching; accepts words, follows redirects
//   ST_HALTED | HLT accepted; pc/count frozen, only rst leaves
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [15:0]        redirect_pc,
    input  logic               stall,
    fetch_unit_if.master       imem,
    output logic [15:0]        pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [15:0]        if_id_pc_plus_2,
    output logic               if_id_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [15:0]  pc_plus_2;
    logic         in_run;
    logic         accept;

    CLA_16b u_pc_adder (
        .a   (pc),
        .b   (PC_STEP),
        .sub (1'b0),
        .sum (pc_plus_2)
    );

    assign in_run    = (state == ST_RUN);
    assign accept    = in_run & imem.ready & ~stall & ~redirect;
    assign imem.addr = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // Next-state: an accepted HLT word is the only way out of RUN.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (accept && is_halt(imem.rdata)) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    // Outputs decoded from state; request is suppressed while rst is asserted.
    always_comb begin
        imem.req = in_run & ~rst;
        halted   = (state == ST_HALTED);
    end

    // PC, IF/ID latch and accept counter; redirect beats stall beats memory wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_VECTOR;
            if_id_instr     <= '0;
            if_id_pc_plus_2 <= '0;
            if_id_valid     <= 1'b0;
            fetch_count     <= '0;
        end else if (in_run) begin
            if (redirect) begin
                pc          <= {redirect_pc[15:1], 1'b0};
                if_id_valid <= 1'b0;
            end else if (stall) begin
                if_id_valid <= if_id_valid;
            end else if (imem.ready) begin
                if_id_instr     <= imem.rdata;
                if_id_pc_plus_2 <= pc_plus_2;
                if_id_valid     <= 1'b1;
                pc              <= pc_plus_2;
                if (fetch_count != COUNT_MAX) fetch_count <= fetch_count + 16'd1;
            end else begin
                if_id_valid <= 1'b0;
            end
        end else begin
            if (!stall) if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus_2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    fetch_unit_if imem_bus ();

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem            (imem_bus.master),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus_2 (if_id_pc_plus_2),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 16'h0000;
        stall          = 1'b0;
        imem_bus.ready = 1'b0;
        imem_bus.rdata = 16'h0000;

        // Reset for two cycles
        @(negedge clk);
        tick();
        tick();
        check("rst_pc", pc, 16'h0000);
        check("rst_valid", {15'd0, if_id_valid}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_count", fetch_count, 16'h0000);
        check("rst_instr", if_id_instr, 16'h0000);
        check("rst_pp2", if_id_pc_plus_2, 16'h0000);
        check("rst_req", {15'd0, imem_bus.req}, 16'd0);

        // Sequential fetch from the reset vector
        rst            = 1'b0;
        imem_bus.ready = 1'b1;
        imem_bus.rdata = 16'h1234;
        #1;
        check("run_req", {15'd0, imem_bus.req}, 16'd1);
        check("addr0", imem_bus.addr, 16'h0000);
        tick();
        check("addr1", imem_bus.addr, 16'h0002);
        check("lat_instr", if_id_instr, 16'h1234);
        check("lat_pp2", if_id_pc_plus_2, 16'h0002);
        check("lat_valid", {15'd0, if_id_valid}, 16'd1);
        imem_bus.rdata = 16'h2345;
        tick();
        check("addr2", imem_bus.addr, 16'h0004);
        imem_bus.rdata = 16'h3456;
        tick();
        check("addr3", imem_bus.addr, 16'h0006);
        check("count3", fetch_count, 16'd3);
        check("instr3", if_id_instr, 16'h3456);

        // Redirect wins over stall, odd target aligned down
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        stall       = 1'b1;
        tick();
        check("redir_pc", pc, 16'h0040);
        check("redir_valid", {15'd0, if_id_valid}, 16'd0);
        check("redir_count", fetch_count, 16'd3);
        redirect = 1'b0;
        stall    = 1'b0;

        // Accept, then stall holds IF/ID and pc
        imem_bus.rdata = 16'h5555;
        tick();
        check("acc_pc", pc, 16'h0042);
        check("acc_instr", if_id_instr, 16'h5555);
        stall          = 1'b1;
        imem_bus.rdata = 16'h6666;
        tick();
        check("stall_pc", pc, 16'h0042);
        check("stall_instr", if_id_instr, 16'h5555);
        check("stall_pp2", if_id_pc_plus_2, 16'h0042);
        check("stall_valid", {15'd0, if_id_valid}, 16'd1);
        check("stall_count", fetch_count, 16'd4);
        stall = 1'b0;

        // Memory wait at 0x0010
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect       = 1'b0;
        imem_bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_pc", pc, 16'h0010);
            check("wait_valid", {15'd0, if_id_valid}, 16'd0);
        end
        imem_bus.ready = 1'b1;
        imem_bus.rdata = 16'h7777;
        tick();
        check("wait_pp2", if_id_pc_plus_2, 16'h0012);
        check("wait_done_valid", {15'd0, if_id_valid}, 16'd1);
        check("wait_count", fetch_count, 16'd5);

        // Halt at 0x0020
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect       = 1'b0;
        imem_bus.rdata = 16'hF000;
        tick();
        check("hlt_halted", {15'd0, halted}, 16'd1);
        check("hlt_pc", pc, 16'h0022);
        check("hlt_instr", if_id_instr, 16'hF000);
        check("hlt_valid", {15'd0, if_id_valid}, 16'd1);
        check("hlt_req", {15'd0, imem_bus.req}, 16'd0);
        check("hlt_count", fetch_count, 16'd6);
        redirect       = 1'b1;
        redirect_pc    = 16'h0100;
        stall          = 1'b1;
        imem_bus.rdata = 16'h1111;
        tick();
        check("hlt_redir_pc", pc, 16'h0022);
        check("hlt_stall_valid", {15'd0, if_id_valid}, 16'd1);
        stall = 1'b0;
        tick();
        check("hlt_bubble", {15'd0, if_id_valid}, 16'd0);
        check("hlt_frozen_pc", pc, 16'h0022);
        check("hlt_frozen_count", fetch_count, 16'd6);
        check("hlt_instr_hold", if_id_instr, 16'hF000);
        redirect = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_req_low", {15'd0, imem_bus.req}, 16'd0);
        tick();
        check("hlt_rst_pc", pc, 16'h0000);
        check("hlt_rst_halted", {15'd0, halted}, 16'd0);
        check("hlt_rst_count", fetch_count, 16'd0);
        rst = 1'b0;

        // PC wrap
        imem_bus.rdata = 16'h0000;
        redirect       = 1'b1;
        redirect_pc    = 16'hFFFE;
        tick();
        check("wrap_pc0", pc, 16'hFFFE);
        redirect = 1'b0;
        tick();
        check("wrap_pc1", pc, 16'h0000);
        check("wrap_pp2", if_id_pc_plus_2, 16'h0000);
        tick();
        check("wrap_pc2", pc, 16'h0002);
        check("wrap_pp2b", if_id_pc_plus_2, 16'h0002);

        // Counter saturation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (65534) tick();
        check("sat_fffe", fetch_count, 16'hFFFE);
        tick();
        check("sat_ffff", fetch_count, 16'hFFFF);
        tick();
        check("sat_hold", fetch_count, 16'hFFFF);
        check("sat_running", {15'd0, halted}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 redirect  input  1  taken-branch indication from branch resolution in ID.
REQ-004 redirect_pc  input  16  branch target; valid while redirect=1.
REQ-005 stall  input  1  hazard stall from ID; holds IF/ID contents.
REQ-006 imem_ready  input  1  instruction memory has valid data for imem_addr this cycle.
REQ-007 imem_rdata  input  16  instruction word for imem_addr.
REQ-008 imem_req  output  1  fetch request.
REQ-009 imem_addr  output  16  fetch address; equals pc.
REQ-010 pc  output  16  current fetch PC.
REQ-011 if_id_instr  output  16  latched instruction.
REQ-012 if_id_pc_plus_2  output  16  latched PC+2 of that instruction, consumed by branch resolution.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-014 halted  output  1  fetch has stopped on HLT.
REQ-015 fetch_count  output  16  accepted-instruction counter.

Function
REQ-016 States: RUN, HALTED.
- No other states exist.
REQ-017 imem_req=1 in RUN; imem_req=0 in HALTED and during rst.
REQ-018 Accept condition: RUN & imem_ready & ~stall & ~redirect.
- On accept: if_id_instr<=imem_rdata, if_id_pc_plus_2<=pc+2, if_id_valid<=1, pc<=pc+2.
- On accept: fetch_count increments by 1 and saturates at 0xFFFF.
REQ-019 Redirect has highest priority in RUN, over stall and imem_ready.
- pc<={redirect_pc[15:1],1'b0}.
- if_id_valid<=0; the current fetch is discarded.
- fetch_count unchanged.
REQ-020 RUN & stall & ~redirect: pc, if_id_instr, if_id_pc_plus_2 and if_id_valid hold.
REQ-021 RUN & ~imem_ready & ~stall & ~redirect: pc holds and if_id_valid<=0 (bubble).
REQ-022 PC increment is modulo 2^16.
- 0xFFFE+2=0x0000, with no error indication.
REQ-023 On an accepted word with opcode imem_rdata[15:12]=HLT (4'hF):
- the word is latched normally;
- state goes RUN->HALTED;
- pc stays at the HLT address + 2.
REQ-024 In HALTED:
- pc and fetch_count frozen; halted=1.
- redirect ignored.
- if_id_valid<=0 on the first cycle with stall=0; IF/ID holds while stall=1.
REQ-025 Only rst leaves HALTED.
REQ-026 Latency: an instruction presented with imem_ready in cycle N is visible on if_id_* in cycle N+1.
REQ-027 imem_addr is combinationally equal to pc.
- It changes only on the clock edge following a redirect or an accept.

Reset
REQ-028 When rst=1 at a clock edge, the next-cycle values are:
- state=RUN, pc=0x0000, if_id_instr=0x0000, if_id_pc_plus_2=0x0000;
- if_id_valid=0, halted=0, fetch_count=0x0000.
REQ-029 rst overrides redirect, stall and imem_ready in any state, including mid-stall and HALTED.
REQ-030 imem_req is 0 in any cycle where rst=1.

Structure
REQ-031 A shared package holds the following constants:
- state encoding (RUN=1'b0, HALTED=1'b1);
- HLT opcode 4'hF;
- reset vector 16'h0000;
- instruction width 16.
REQ-032 PC+2 uses one instance of the existing CLA_16b adder with sub=0; no other sub-module.

Verification
REQ-033 Reset scenario:
- Stimulus: rst 2 cycles, then imem_ready=1 constant.
- Required response: imem_addr 0x0000, 0x0002, 0x0004 on successive cycles; fetch_count=3 after 3 accepts.
REQ-034 Redirect versus stall:
- Stimulus: redirect=1, redirect_pc=0x0041 and stall=1 in the same cycle.
- Required response: next pc=0x0040; if_id_valid=0; count unchanged.
REQ-035 Memory wait:
- Stimulus: imem_ready=0 for 3 cycles at pc=0x0010.
- Required response: pc holds 0x0010; if_id_valid=0 for 3 cycles.
- Then imem_ready=1 -> if_id_pc_plus_2=0x0012.
REQ-036 Halt:
- Stimulus: fetch 0xF000 at pc=0x0020, then redirect=1 to 0x0100.
- Required response: halted=1; pc=0x0022 frozen; redirect ignored; imem_req=0.
- Then rst -> pc=0x0000, halted=0.
REQ-037 Wrap and saturation:
- Stimulus: redirect to 0xFFFE, accept 2 words.
- Required response: pc goes 0xFFFE->0x0000->0x0002.
- Separately, preload 0xFFFF accepts -> fetch_count stays 0xFFFF.
